// File: rtl/nco_pkg.sv
// Shared constants for the NCO frame decoder: opcodes, frame field positions
// and tuning-word limits.
package nco_pkg;

   localparam int unsigned NCO_TW_WIDTH   = 24;
   localparam int unsigned NCO_MAX_VOICES = 16;

   localparam int unsigned NCO_OP_MSB    = 31;
   localparam int unsigned NCO_OP_LSB    = 28;
   localparam int unsigned NCO_VOICE_MSB = 27;
   localparam int unsigned NCO_VOICE_LSB = 24;
   localparam int unsigned NCO_PAY_MSB   = 23;
   localparam int unsigned NCO_PAY_LSB   = 0;

   typedef logic [3:0] nco_op_t;

   localparam nco_op_t NCO_OP_NOP          = 4'h0;
   localparam nco_op_t NCO_OP_WRITE        = 4'h1;
   localparam nco_op_t NCO_OP_COMMIT       = 4'h2;
   localparam nco_op_t NCO_OP_WRITE_COMMIT = 4'h3;
   localparam nco_op_t NCO_OP_CLEAR        = 4'h4;

endpackage

// File: rtl/nco_tw_bank.sv
// One voice's shadow/active tuning-word pair. A write with a commit on the
// same edge forwards the new payload straight into the active register.
module nco_tw_bank
   import nco_pkg::*;
#(
   parameter int unsigned TW_WIDTH = NCO_TW_WIDTH
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_write,
   input  logic                i_commit,
   input  logic                i_clear,
   input  logic [TW_WIDTH-1:0] i_payload,
   output logic [TW_WIDTH-1:0] o_active
);

   logic [TW_WIDTH-1:0] shadow_q;
   logic [TW_WIDTH-1:0] active_q;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (i_write) begin
            shadow_q <= i_payload;
         end
         if (i_commit) begin
            active_q <= i_write ? i_payload : shadow_q;
         end
      end
   end

   assign o_active = active_q;

endmodule

// File: rtl/nco_frame_decoder.sv
// Decodes SPI frame words into per-voice NCO tuning words with atomic commit.
// Optional saturating reject counter enabled by defining NCO_FRAME_ERR_CNT_EN.
module nco_frame_decoder
   import nco_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned TW_WIDTH   = NCO_TW_WIDTH
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic [31:0]                    i_frame,
   input  logic                           i_frame_valid,
   output logic [NUM_VOICES*TW_WIDTH-1:0] o_tuning_words,
   output logic                           o_update_pulse,
   output logic                           o_frame_error
`ifdef NCO_FRAME_ERR_CNT_EN
   ,
   output logic [7:0]                     o_err_count
`endif
);

   if (NUM_VOICES < 1 || NUM_VOICES > NCO_MAX_VOICES) begin : g_bad_voices
      $error("NUM_VOICES out of range 1..16");
   end
   if (TW_WIDTH != NCO_TW_WIDTH) begin : g_bad_width
      $error("TW_WIDTH must be 24");
   end

   logic        cap_valid_q;
   logic [31:0] cap_frame_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cap_valid_q <= 1'b0;
         cap_frame_q <= '0;
      end else begin
         cap_valid_q <= i_frame_valid;
         if (i_frame_valid) begin
            cap_frame_q <= i_frame;
         end
      end
   end

   nco_op_t             op;
   logic [3:0]          voice;
   logic [TW_WIDTH-1:0] payload;
   logic                voice_ok;

   assign op       = cap_frame_q[NCO_OP_MSB:NCO_OP_LSB];
   assign voice    = cap_frame_q[NCO_VOICE_MSB:NCO_VOICE_LSB];
   assign payload  = cap_frame_q[NCO_PAY_MSB:NCO_PAY_LSB];
   assign voice_ok = {28'd0, voice} < NUM_VOICES;

   logic wr_en;
   logic commit_en;
   logic clear_en;
   logic frame_err;

   always_comb begin
      wr_en     = 1'b0;
      commit_en = 1'b0;
      clear_en  = 1'b0;
      frame_err = 1'b0;
      if (cap_valid_q) begin
         case (op)
            NCO_OP_NOP: ;
            NCO_OP_WRITE: begin
               wr_en     = voice_ok;
               frame_err = !voice_ok;
            end
            NCO_OP_COMMIT: commit_en = 1'b1;
            NCO_OP_WRITE_COMMIT: begin
               wr_en     = voice_ok;
               commit_en = voice_ok;
               frame_err = !voice_ok;
            end
            NCO_OP_CLEAR: clear_en = 1'b1;
            default: frame_err = 1'b1;
         endcase
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      nco_tw_bank #(
         .TW_WIDTH (TW_WIDTH)
      ) u_bank (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_write   (wr_en && (voice == 4'(v))),
         .i_commit  (commit_en),
         .i_clear   (clear_en),
         .i_payload (payload),
         .o_active  (o_tuning_words[v*TW_WIDTH +: TW_WIDTH])
      );
   end

   logic update_q;
   logic error_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         update_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         update_q <= commit_en || clear_en;
         error_q  <= frame_err;
      end
   end

   assign o_update_pulse = update_q;
   assign o_frame_error  = error_q;

`ifdef NCO_FRAME_ERR_CNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         err_count_q <= '0;
      end else if (frame_err && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign o_err_count = err_count_q;
`endif

endmodule

// File: doc/nco_frame_decoder.md
# nco_frame_decoder

Consumes the 32-bit parallel words assembled by the NCO SPI interface and turns them into per-voice NCO tuning words. Writes land in shadow registers. A commit copies all shadows to the active registers at once, so every voice retunes on the same clock. Sits between the SPI interface and the NCO phase accumulators.

## Interface
- NUM_VOICES, 4, number of NCO voices, legal range 1..16
- TW_WIDTH, 24, tuning word width, fixed by frame payload; must equal 24

- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_frame  in  32  frame word from the SPI interface
- i_frame_valid  in  1  one-cycle strobe, i_frame valid this cycle
- o_tuning_words  out  NUM_VOICES*TW_WIDTH  active tuning words; voice v at [v*24 +: 24]
- o_update_pulse  out  1  one-cycle pulse when the active registers change
- o_frame_error  out  1  one-cycle pulse on a rejected frame
- o_err_count  out  8  saturating count of rejected frames (NCO_FRAME_ERR_CNT_EN only)

## Operation
- Frame fields:
  - [31:28] opcode
  - [27:24] voice index
  - [23:0] payload
- Opcodes:
  - 0x0 NOP: no effect, no pulse
  - 0x1 WRITE: shadow[voice] <= payload
  - 0x2 COMMIT: active[v] <= shadow[v] for all v; voice and payload ignored
  - 0x3 WRITE_COMMIT: shadow[voice] <= payload; same edge, active <= shadows including the new value
  - 0x4 CLEAR: all shadow and active <= 0; pulses o_update_pulse
  - 0x5..0xF: illegal; o_frame_error pulses, no state change
- WRITE or WRITE_COMMIT with voice >= NUM_VOICES is an error. Nothing is written or committed and o_update_pulse stays low.
- Two-stage pipeline:
  - Stage 1: capture register, loaded when i_frame_valid is high.
  - Stage 2: decode/execute.
  - Frames on consecutive cycles are accepted and executed in arrival order. There is no backpressure.
- o_update_pulse is asserted by COMMIT, WRITE_COMMIT and CLEAR, even when the active values do not change.
- No FSM beyond the valid pipeline. The block is never busy.

## Timing
- Frame strobed at edge E is captured at E and executed at E+1.
- Shadow and active registers, o_update_pulse and o_frame_error all take their new values at E+1 and are visible in the cycle after E+1.
- Pulses are exactly one cycle wide. Back-to-back commits give a pulse on each consecutive cycle.
- Reset values:
  - o_tuning_words all 0, shadows all 0
  - o_update_pulse 0, o_frame_error 0, o_err_count 0
  - capture valid bit 0
- Reset asserted on the same edge as i_frame_valid, or with a frame in stage 1: the frame is discarded. Reset wins.
- WRITE to voice A at E followed by COMMIT at E+1: the commit sees the new shadow. There is no hazard because execute order equals arrival order.

## Configuration
- NCO_FRAME_ERR_CNT_EN defined:
  - o_err_count exists.
  - Increments by 1 on every o_frame_error pulse, saturating at 255.
  - Cleared only by reset.
- Not defined: the o_err_count port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package nco_pkg holds:
  - opcode constants (NCO_OP_NOP .. NCO_OP_CLEAR)
  - field bit positions
  - NCO_TW_WIDTH = 24
  - NCO_MAX_VOICES = 16
- Sub-module nco_tw_bank: one voice's shadow and active register pair, with write, commit and clear inputs. Instantiated NUM_VOICES times in a generate loop.

## Test plan
- Reset, then WRITE voice 1 payload 0x123456, then COMMIT:
  - o_tuning_words[47:24] = 0x123456 one cycle after the commit executes
  - exactly one o_update_pulse
  - other voices stay 0
- WRITE voice 0 = 0x000100 with no commit: active voice 0 stays 0. WRITE_COMMIT voice 2 = 0xABCDEF: voice 0 becomes 0x000100 and voice 2 becomes 0xABCDEF on the same edge.
- Invalid frames 0x7000_0000, then 0x1500_0001 with NUM_VOICES=4:
  - two o_frame_error pulses
  - no shadow or active change
  - o_err_count = 2 (macro on)
- Back-to-back frames every cycle: WRITE v3 = 0x000005, COMMIT, CLEAR:
  - voice 3 shows 5 for one cycle, then 0
  - o_update_pulse high for two consecutive cycles
- 300 illegal frames with the macro on: o_err_count saturates at 255.
- i_reset asserted the same cycle a COMMIT is in stage 1, after shadows were written: actives stay 0, no pulse, shadows 0.
